// File: rtl/i2s_output.sv
// i2s_output: I2S master transmitter for the external audio DAC.
//
// Takes one stereo pair at a time from a stb/ack handshake and keeps it in a
// one-deep holding buffer. It generates MCLK, BCLK and LRCLK itself and sends
// each frame MSB-first in Philips I2S format, with 64 BCLK per frame (32 per slot).
//
// Ports:
//   clk          system clock (clk_50)
//   rst_n        asynchronous active-low reset
//   in_left      left sample, two's complement
//   in_right     right sample, two's complement
//   in_stb       sample pair valid
//   in_ack       holding buffer empty; a transfer happens when in_stb && in_ack
//   mclk_out     DAC master clock, clk / (2*MCLK_DIV)
//   bclk_out     bit clock, clk / (2*BCLK_DIV)
//   lrclk_out    word select, 0 = left slot, 1 = right slot
//   dout_out     serial data, updated on the BCLK falling edge
//   underrun_out one-clk pulse when a frame starts with no buffered pair
module i2s_output #(
  parameter int SAMPLE_WIDTH = 24,
  parameter int BCLK_DIV     = 12,
  parameter int MCLK_DIV     = 2
) (
  input  logic                    clk,
  input  logic                    rst_n,
  input  logic [SAMPLE_WIDTH-1:0] in_left,
  input  logic [SAMPLE_WIDTH-1:0] in_right,
  input  logic                    in_stb,
  output logic                    in_ack,
  output logic                    mclk_out,
  output logic                    bclk_out,
  output logic                    lrclk_out,
  output logic                    dout_out,
  output logic                    underrun_out
);

  localparam int BCW = (BCLK_DIV > 1) ? $clog2(BCLK_DIV) : 1;
  localparam int MCW = (MCLK_DIV > 1) ? $clog2(MCLK_DIV) : 1;
  localparam logic [BCW-1:0] BCLK_TC  = BCW'(BCLK_DIV - 1);
  localparam logic [BCW-1:0] BCLK_ONE = BCW'(1);
  localparam logic [MCW-1:0] MCLK_TC  = MCW'(MCLK_DIV - 1);
  localparam logic [MCW-1:0] MCLK_ONE = MCW'(1);

  // Bit k of a slot (1..SAMPLE_WIDTH) is sample[SAMPLE_WIDTH-k]. k = 0 and any
  // slot position past the sample width give 0.
  function automatic logic select_bit(input logic [SAMPLE_WIDTH-1:0] s,
                                      input logic [5:0]              k);
    logic r;
    r = 1'b0;
    for (int i = 0; i < SAMPLE_WIDTH; i++) begin
      if (k == 6'(SAMPLE_WIDTH - i)) begin
        r = s[i];
      end else begin
        r = r;
      end
    end
    return r;
  endfunction

  logic [MCW-1:0]          mclk_cnt_r;
  logic                    mclk_r;
  logic [BCW-1:0]          bclk_cnt_r;
  logic                    bclk_r;
  logic [5:0]              bit_cnt_r;
  logic                    lrclk_r;
  logic                    dout_r;
  logic                    underrun_r;
  logic [SAMPLE_WIDTH-1:0] frame_left_r;
  logic [SAMPLE_WIDTH-1:0] frame_right_r;
  logic [SAMPLE_WIDTH-1:0] buf_left_r;
  logic [SAMPLE_WIDTH-1:0] buf_right_r;
  logic                    full_r;

  logic                    fall_s;
  logic                    wrap_s;
  logic                    xfer_s;
  logic [5:0]              bit_nxt_s;
  logic [SAMPLE_WIDTH-1:0] slot_s;
  logic                    dout_nxt_s;

  // Decode the BCLK falling edge, frame wrap and handshake transfer.
  always_comb begin
    fall_s    = (bclk_cnt_r == BCLK_TC) && bclk_r;
    bit_nxt_s = bit_cnt_r + 6'd1;
    wrap_s    = fall_s && (bit_nxt_s == 6'd0);
    xfer_s    = in_stb && !full_r;
  end

  // Choose the data bit for the slot position that is about to start.
  always_comb begin
    slot_s = frame_left_r;
    if (bit_nxt_s[5]) begin
      slot_s = frame_right_r;
    end else begin
      slot_s = frame_left_r;
    end
    dout_nxt_s = select_bit(slot_s, {1'b0, bit_nxt_s[4:0]});
  end

  // Free-running MCLK divider. It does not depend on the BCLK prescaler.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      mclk_cnt_r <= {MCW{1'b0}};
      mclk_r     <= 1'b0;
    end else if (mclk_cnt_r == MCLK_TC) begin
      mclk_cnt_r <= {MCW{1'b0}};
      mclk_r     <= ~mclk_r;
    end else begin
      mclk_cnt_r <= mclk_cnt_r + MCLK_ONE;
    end
  end

  // BCLK prescaler. The first rising edge is at BCLK_DIV cycles after reset.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      bclk_cnt_r <= {BCW{1'b0}};
      bclk_r     <= 1'b0;
    end else if (bclk_cnt_r == BCLK_TC) begin
      bclk_cnt_r <= {BCW{1'b0}};
      bclk_r     <= ~bclk_r;
    end else begin
      bclk_cnt_r <= bclk_cnt_r + BCLK_ONE;
    end
  end

  // Holding buffer. Only an empty buffer can accept a transfer, so a write and
  // a frame load never collide. A load on the wrap empties the buffer.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      full_r      <= 1'b0;
      buf_left_r  <= {SAMPLE_WIDTH{1'b0}};
      buf_right_r <= {SAMPLE_WIDTH{1'b0}};
    end else if (xfer_s) begin
      full_r      <= 1'b1;
      buf_left_r  <= in_left;
      buf_right_r <= in_right;
    end else if (wrap_s) begin
      full_r      <= 1'b0;
    end else begin
      full_r      <= full_r;
    end
  end

  // Serialiser: on each BCLK falling edge, step the bit counter, update LRCLK
  // and DOUT, and load a new frame on the 63->0 wrap. The bit sent at k = 0 is
  // always 0, so the newly loaded frame is not needed until the next edge.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      bit_cnt_r     <= 6'd63;
      lrclk_r       <= 1'b1;
      dout_r        <= 1'b0;
      underrun_r    <= 1'b0;
      frame_left_r  <= {SAMPLE_WIDTH{1'b0}};
      frame_right_r <= {SAMPLE_WIDTH{1'b0}};
    end else begin
      underrun_r <= 1'b0;
      if (fall_s) begin
        bit_cnt_r <= bit_nxt_s;
        lrclk_r   <= bit_nxt_s[5];
        dout_r    <= dout_nxt_s;
      end else begin
        bit_cnt_r <= bit_cnt_r;
      end
      if (wrap_s && full_r) begin
        frame_left_r  <= buf_left_r;
        frame_right_r <= buf_right_r;
      end else if (wrap_s) begin
        frame_left_r  <= {SAMPLE_WIDTH{1'b0}};
        frame_right_r <= {SAMPLE_WIDTH{1'b0}};
        underrun_r    <= 1'b1;
      end else begin
        frame_left_r  <= frame_left_r;
      end
    end
  end

  assign in_ack       = ~full_r;
  assign mclk_out     = mclk_r;
  assign bclk_out     = bclk_r;
  assign lrclk_out    = lrclk_r;
  assign dout_out     = dout_r;
  assign underrun_out = underrun_r;

endmodule

// File: tb/tb_i2s_output.sv
module tb_i2s_output;

  localparam int SW = 16;

  logic          clk = 1'b0;
  logic          rst_n;
  logic [SW-1:0] in_left;
  logic [SW-1:0] in_right;
  logic          in_stb;
  logic          in_ack;
  logic          mclk_out;
  logic          bclk_out;
  logic          lrclk_out;
  logic          dout_out;
  logic          underrun_out;

  i2s_output #(.SAMPLE_WIDTH(SW), .BCLK_DIV(2), .MCLK_DIV(2)) dut (
    .clk          (clk),
    .rst_n        (rst_n),
    .in_left      (in_left),
    .in_right     (in_right),
    .in_stb       (in_stb),
    .in_ack       (in_ack),
    .mclk_out     (mclk_out),
    .bclk_out     (bclk_out),
    .lrclk_out    (lrclk_out),
    .dout_out     (dout_out),
    .underrun_out (underrun_out)
  );

  always #5 clk = ~clk;

  typedef struct packed {
    logic d;
    logic lr;
    logic ur;
  } exp_t;

  exp_t        bit_q[$];   // expected DOUT/LRCLK/underrun at each BCLK falling edge
  logic [31:0] pair_q[$];  // pairs accepted by the DUT but not yet played
  int          checks = 0;
  int          errors = 0;
  int          cyc    = 0;
  int          xfers  = 0;
  logic        exp_lr;
  logic        exp_dout;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%0h expected=%0h cycle=%0d", tag, obs, exp, cyc);
    end
  endtask

  // Expected Philips I2S frame: MSB at k=1, zero padding after the sample bits.
  task automatic push_frame(input logic [SW-1:0] l, input logic [SW-1:0] r, input logic silent);
    for (int j = 0; j < 64; j++) begin
      exp_t        e;
      int          k;
      logic [SW-1:0] s;
      k    = j % 32;
      s    = (j < 32) ? l : r;
      e.lr = (j >= 32);
      e.d  = (k >= 1 && k <= SW) ? s[SW-k] : 1'b0;
      e.ur = silent && (j == 0);
      bit_q.push_back(e);
    end
  endtask

  task automatic check_reset_values(input string tag);
    chk({tag, "_mclk"}, 32'(mclk_out), 32'd0);
    chk({tag, "_bclk"}, 32'(bclk_out), 32'd0);
    chk({tag, "_lrclk"}, 32'(lrclk_out), 32'd1);
    chk({tag, "_dout"}, 32'(dout_out), 32'd0);
    chk({tag, "_underrun"}, 32'(underrun_out), 32'd0);
    chk({tag, "_in_ack"}, 32'(in_ack), 32'd1);
  endtask

  task automatic reset_and_release(input logic stb_during);
    in_stb   = stb_during;
    in_left  = 16'hDEAD;
    in_right = 16'hBEEF;
    rst_n    = 1'b0;
    repeat (3) @(negedge clk);
    check_reset_values("reset");
    in_stb = 1'b0;
    bit_q.delete();
    pair_q.delete();
    exp_lr   = 1'b1;
    exp_dout = 1'b0;
    cyc      = 0;
    xfers    = 0;
    rst_n    = 1'b1;
  endtask

  // mode 0: no producer; 1: one pair offered from cycle stb_at; 2: in_stb held high,
  // data stepping after every transfer.
  task automatic play(input int ncyc, input int mode, input int stb_at,
                      input logic [SW-1:0] l0, input logic [SW-1:0] r0);
    logic xp;
    exp_t e;
    if (mode == 2) begin
      in_stb   = 1'b1;
      in_left  = l0;
      in_right = r0;
    end
    for (int i = 0; i < ncyc; i++) begin
      if (mode == 1 && cyc + 1 == stb_at) begin
        in_stb   = 1'b1;
        in_left  = l0;
        in_right = r0;
      end
      xp = in_stb && in_ack;
      @(posedge clk);
      @(negedge clk);
      cyc++;
      // Frame boundaries fall at cycle 4 and every 256 cycles after it.
      if (cyc >= 4 && (cyc - 4) % 256 == 0) begin
        if (pair_q.size() > 0) begin
          logic [31:0] p;
          p = pair_q.pop_front();
          push_frame(p[31:16], p[15:0], 1'b0);
        end else begin
          push_frame(16'h0000, 16'h0000, 1'b1);
        end
      end
      if (xp) begin
        pair_q.push_back({in_left, in_right});
        xfers++;
        if (mode == 1) begin
          in_stb = 1'b0;
        end else begin
          in_left  = in_left + 16'h0101;
          in_right = in_right - 16'h0003;
        end
      end
      chk("bclk", 32'(bclk_out), 32'((cyc / 2) % 2));
      chk("mclk", 32'(mclk_out), 32'((cyc / 2) % 2));
      chk("in_ack", 32'(in_ack), 32'(pair_q.size() == 0));
      if (cyc >= 4 && cyc % 4 == 0) begin
        chk("scoreboard_nonempty", 32'(bit_q.size() > 0), 32'd1);
        if (bit_q.size() > 0) begin
          e        = bit_q.pop_front();
          exp_lr   = e.lr;
          exp_dout = e.d;
          chk("underrun_edge", 32'(underrun_out), 32'(e.ur));
        end
      end else begin
        chk("underrun_idle", 32'(underrun_out), 32'd0);
      end
      chk("lrclk", 32'(lrclk_out), 32'(exp_lr));
      chk("dout", 32'(dout_out), 32'(exp_dout));
    end
  endtask

  initial begin
    rst_n    = 1'b0;
    in_stb   = 1'b0;
    in_left  = 16'h0000;
    in_right = 16'h0000;
    exp_lr   = 1'b1;
    exp_dout = 1'b0;

    // Idle after reset (in_stb high while in reset must be ignored): silence, underrun every frame.
    reset_and_release(1'b1);
    play(520, 0, 0, 16'h0000, 16'h0000);
    chk("idle_no_xfer", 32'(xfers), 32'd0);

    // One pair written before the first wrap, followed by silence.
    reset_and_release(1'b0);
    play(520, 1, 1, 16'hA5C3, 16'h8001);
    chk("single_xfers", 32'(xfers), 32'd1);

    // Transfer in the same cycle as the 63->0 wrap at cycle 260.
    reset_and_release(1'b0);
    play(800, 1, 260, 16'h1234, 16'hFEDC);
    chk("wrap_xfers", 32'(xfers), 32'd1);

    // Back-to-back producer over 10 frames.
    reset_and_release(1'b0);
    play(2560, 2, 0, 16'h0100, 16'h8000);
    chk("b2b_xfers", 32'(xfers), 32'd11);
    chk("b2b_pending", 32'(pair_q.size()), 32'd1);
    chk("b2b_bits_left", 32'(bit_q.size()), 32'd0);

    // Reset in the middle of the right slot while a pair is buffered.
    reset_and_release(1'b0);
    play(200, 2, 0, 16'h7777, 16'h1111);
    in_stb = 1'b0;
    #2;
    rst_n = 1'b0;
    #1;
    check_reset_values("abort");
    bit_q.delete();
    pair_q.delete();
    exp_lr   = 1'b1;
    exp_dout = 1'b0;
    repeat (2) @(negedge clk);
    cyc   = 0;
    xfers = 0;
    rst_n = 1'b1;
    play(300, 0, 0, 16'h0000, 16'h0000);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
